// File: rtl/pc_branch_unit.sv
//------------------------------------------------------------------------------
// pc_branch_unit
//   Fetch-PC register with zero-latency branch resolution (B / BR), a one-slot
//   redirect bubble and a sticky HALT. Optional TAKEN_CNT_EN adds taken_count.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_branch_unit #(
  parameter int unsigned           PC_WIDTH  = 16,
  parameter int unsigned           IMM_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 branch_valid,
  input  logic                 branch_reg,
  input  logic [2:0]           cond,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [PC_WIDTH-1:0]  rs_data,
  input  logic [2:0]           flags,
  input  logic [PC_WIDTH-1:0]  decode_pc,
  output logic [PC_WIDTH-1:0]  pc_fetch,
  output logic [PC_WIDTH-1:0]  pcs,
  output logic                 flush,
  output logic                 taken,
  output logic                 halted
`ifdef TAKEN_CNT_EN
  ,
  output logic [15:0]          taken_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] C_TWO = PC_WIDTH'(2);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  logic                w_n, w_z, w_v;
  logic                w_cond_true;
  logic [PC_WIDTH-1:0] w_imm_sx;
  logic [PC_WIDTH-1:0] w_target;
  logic                w_taken;
  logic                w_flush;

  assign w_n = flags[2];
  assign w_z = flags[1];
  assign w_v = flags[0];

  always_comb begin
    w_cond_true = 1'b0;
    unique case (cond)
      3'b000:  w_cond_true = ~w_z;
      3'b001:  w_cond_true = w_z;
      3'b010:  w_cond_true = ~w_z & ~w_n;
      3'b011:  w_cond_true = w_n;
      3'b100:  w_cond_true = w_z | ~w_n;
      3'b101:  w_cond_true = w_n | w_z;
      3'b110:  w_cond_true = w_v;
      default: w_cond_true = 1'b1;
    endcase
  end

  // Halfword offset: sign-extend to PC width, then scale to bytes.
  assign w_imm_sx = {{(PC_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign pcs      = decode_pc + C_TWO;
  assign w_target = branch_reg ? rs_data : (pcs + {w_imm_sx[PC_WIDTH-2:0], 1'b0});

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    w_taken = 1'b0;
    w_flush = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = ST_HALT;
          end else if (branch_valid && w_cond_true) begin
            w_taken = 1'b1;
            w_flush = 1'b1;
            pc_d    = w_target;
            state_d = ST_REDIRECT;
          end else begin
            pc_d = pc_q + C_TWO;
          end
        end
      end
      ST_REDIRECT: begin
        if (!stall) begin
          pc_d    = pc_q + C_TWO;
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign pc_fetch = pc_q;
  assign taken    = w_taken & ~rst;
  assign flush    = w_flush & ~rst;
  assign halted   = (state_q == ST_HALT) & ~rst;

`ifdef TAKEN_CNT_EN
  logic [15:0] taken_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_count_q <= '0;
    end else if (w_taken && (taken_count_q != 16'hFFFF)) begin
      taken_count_q <= taken_count_q + 16'd1;
    end
  end

  assign taken_count = taken_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
//------------------------------------------------------------------------------
// tb_pc_branch_unit
//   Directed bench for pc_branch_unit with a queue-based scoreboard.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, halt, branch_valid, branch_reg;
  logic [2:0]  cond, flags;
  logic [8:0]  imm;
  logic [15:0] rs_data, decode_pc;
  logic [15:0] pc_fetch, pcs;
  logic        flush, taken, halted;
`ifdef TAKEN_CNT_EN
  logic [15:0] taken_count;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic        tk;
    logic        fl;
    logic        hl;
    logic [15:0] pcs;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pc_branch_unit #(.PC_WIDTH(16), .IMM_WIDTH(9), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .halt         (halt),
    .branch_valid (branch_valid),
    .branch_reg   (branch_reg),
    .cond         (cond),
    .imm          (imm),
    .rs_data      (rs_data),
    .flags        (flags),
    .decode_pc    (decode_pc),
    .pc_fetch     (pc_fetch),
    .pcs          (pcs),
    .flush        (flush),
    .taken        (taken),
    .halted       (halted)
`ifdef TAKEN_CNT_EN
    ,
    .taken_count  (taken_count)
`endif
  );

  task automatic idle();
    rst = 0; stall = 0; halt = 0; branch_valid = 0; branch_reg = 0;
    cond = 3'b000; flags = 3'b000; imm = 9'h000; rs_data = 16'h0000;
    decode_pc = 16'h0000;
  endtask

  task automatic set_b(input logic [15:0] dpc, input logic [2:0] c,
                       input logic [8:0] im, input logic [2:0] f);
    branch_valid = 1; branch_reg = 0; decode_pc = dpc; cond = c; imm = im; flags = f;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs are already set; push expectation, compare at negedge, advance.
  task automatic cyc(input logic [15:0] e_pc, input logic e_tk, input logic e_fl,
                     input logic e_hl);
    exp_t e, g;
    e.pc = e_pc; e.tk = e_tk; e.fl = e_fl; e.hl = e_hl; e.pcs = decode_pc + 16'd2;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    chk("pc_fetch", pc_fetch, g.pc);
    chk("taken",    {15'd0, taken},  {15'd0, g.tk});
    chk("flush",    {15'd0, flush},  {15'd0, g.fl});
    chk("halted",   {15'd0, halted}, {15'd0, g.hl});
    chk("pcs",      pcs, g.pcs);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    // Reset held with a taken branch present.
    rst = 1; set_b(16'h0010, 3'b111, 9'h1FE, 3'b000);
    cyc(16'h0000, 0, 0, 0);
    idle();
    cyc(16'h0000, 0, 0, 0);
    cyc(16'h0002, 0, 0, 0);
    cyc(16'h0004, 0, 0, 0);
    cyc(16'h0006, 0, 0, 0);
    // Unconditional B backwards by one instruction.
    set_b(16'h0010, 3'b111, 9'h1FE, 3'b000);
    cyc(16'h0008, 1, 1, 0);
    cyc(16'h000E, 0, 0, 0);
    idle();
    cyc(16'h0010, 0, 0, 0);
    // Condition codes.
    set_b(16'h0020, 3'b000, 9'h004, 3'b010);
    cyc(16'h0012, 0, 0, 0);
    set_b(16'h0020, 3'b110, 9'h004, 3'b001);
    cyc(16'h0014, 1, 1, 0);
    idle();
    cyc(16'h002A, 0, 0, 0);
    set_b(16'h0020, 3'b001, 9'h004, 3'b000);
    cyc(16'h002C, 0, 0, 0);
    set_b(16'h0020, 3'b101, 9'h004, 3'b000);
    cyc(16'h002E, 0, 0, 0);
    set_b(16'h0020, 3'b100, 9'h004, 3'b100);
    cyc(16'h0030, 0, 0, 0);
    set_b(16'h0040, 3'b010, 9'h000, 3'b000);
    cyc(16'h0032, 1, 1, 0);
    idle();
    cyc(16'h0042, 0, 0, 0);
    // Target wrap-around, then register branch.
    set_b(16'hFFFE, 3'b111, 9'h001, 3'b000);
    cyc(16'h0044, 1, 1, 0);
    idle();
    cyc(16'h0002, 0, 0, 0);
    set_b(16'h0030, 3'b111, 9'h000, 3'b000);
    branch_reg = 1; rs_data = 16'h1234;
    cyc(16'h0004, 1, 1, 0);
    idle();
    cyc(16'h1234, 0, 0, 0);
    // Stall with a taken branch pending, then stall inside REDIRECT.
    set_b(16'h0050, 3'b111, 9'h010, 3'b000);
    stall = 1;
    cyc(16'h1236, 0, 0, 0);
    cyc(16'h1236, 0, 0, 0);
    stall = 0;
    cyc(16'h1236, 1, 1, 0);
    stall = 1;
    cyc(16'h0072, 0, 0, 0);
    stall = 0;
    cyc(16'h0072, 0, 0, 0);
    // Halt wins over a simultaneous branch and sticks.
    halt = 1;
    cyc(16'h0074, 0, 0, 0);
    halt = 0;
    for (int i = 0; i < 5; i++) cyc(16'h0074, 0, 0, 1);
`ifdef TAKEN_CNT_EN
    @(negedge clk);
    chk("taken_count", taken_count, 16'd6);
    @(posedge clk); #1;
`endif
    rst = 1;
    cyc(16'h0074, 0, 0, 0);
    idle();
    cyc(16'h0000, 0, 0, 0);
    // Reset in the same cycle as a taken branch.
    set_b(16'h0100, 3'b111, 9'h000, 3'b000);
    rst = 1;
    cyc(16'h0002, 0, 0, 0);
    idle();
    cyc(16'h0000, 0, 0, 0);
`ifdef TAKEN_CNT_EN
    @(negedge clk);
    chk("taken_count_rst", taken_count, 16'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
